// File: rtl/core_pkg.sv
// Shared control-flow definitions: next-PC operation encodings, 2-bit predictor states,
// and the per-entry status word kept by the branch target buffer.
package core_pkg;

    typedef enum logic [1:0] {
        NPC_SEQ  = 2'd0,
        NPC_JAL  = 2'd1,
        NPC_BR   = 2'd2,
        NPC_JALR = 2'd3
    } npc_op_e;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    // Tag and target widths depend on module parameters, so they live beside this word.
    typedef struct packed {
        logic       valid;
        logic [1:0] ctr;
    } btb_entry_t;

    function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        if (taken) begin
            nxt = (ctr == CTR_ST) ? CTR_ST : ctr + 2'b01;
        end else begin
            nxt = (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'b01;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/btb_array.sv
// Direct-mapped BTB storage: asynchronous read ports for the IF lookup and the EX-stage entry,
// one synchronous write port, asynchronous clear of the status bits.
module btb_array
    import core_pkg::*;
#(
    parameter int PC_WIDTH  = 32,
    parameter int BTB_DEPTH = 64,
    parameter int IDX_BITS  = $clog2(BTB_DEPTH),
    parameter int TAG_W     = PC_WIDTH - IDX_BITS - 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IDX_BITS-1:0] if_idx,
    output btb_entry_t          if_entry,
    output logic [TAG_W-1:0]    if_tag,
    output logic [PC_WIDTH-1:0] if_target,
    input  logic [IDX_BITS-1:0] ex_idx,
    output btb_entry_t          ex_entry,
    output logic [TAG_W-1:0]    ex_tag,
    output logic [PC_WIDTH-1:0] ex_target,
    input  logic                wr_en,
    input  logic [IDX_BITS-1:0] wr_idx,
    input  btb_entry_t          wr_entry,
    input  logic [TAG_W-1:0]    wr_tag,
    input  logic [PC_WIDTH-1:0] wr_target
);

    btb_entry_t          meta_r   [BTB_DEPTH];
    logic [TAG_W-1:0]    tag_r    [BTB_DEPTH];
    logic [PC_WIDTH-1:0] target_r [BTB_DEPTH];

    // Status bits: cleared to invalid / weakly-not-taken on reset, written from EX.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BTB_DEPTH; i++) begin
                meta_r[i] <= '{valid: 1'b0, ctr: CTR_WNT};
            end
        end else if (wr_en) begin
            meta_r[wr_idx] <= wr_entry;
        end
    end

    // Tag and target payload are only meaningful under a valid bit, so they carry no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_r[wr_idx]    <= wr_tag;
            target_r[wr_idx] <= wr_target;
        end
    end

    assign if_entry  = meta_r[if_idx];
    assign if_tag    = tag_r[if_idx];
    assign if_target = target_r[if_idx];
    assign ex_entry  = meta_r[ex_idx];
    assign ex_tag    = tag_r[ex_idx];
    assign ex_target = target_r[ex_idx];

endmodule

// File: rtl/branch_resolve_ctrl.sv
// EX-stage control-hazard unit: BTB/BHT lookup for IF, branch/jump resolution with
// mispredict redirect, predictor training and saturating performance counters.
module branch_resolve_ctrl
    import core_pkg::*;
#(
    parameter int PC_WIDTH   = 32,
    parameter int BTB_DEPTH  = 64,
    parameter int PREDICT_EN = 1,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PC_WIDTH-1:0]  if_pc,
    output logic                 if_pred_taken,
    output logic [PC_WIDTH-1:0]  if_pred_target,
    input  logic                 ex_valid,
    input  logic [1:0]           ex_npc_op,
    input  logic                 ex_branch,
    input  logic                 alu_branch,
    input  logic [PC_WIDTH-1:0]  ex_pc,
    input  logic [PC_WIDTH-1:0]  ex_target,
    input  logic                 ex_pred_taken,
    input  logic [PC_WIDTH-1:0]  ex_pred_target,
    output logic                 redirect,
    output logic [PC_WIDTH-1:0]  redirect_pc,
    output logic [CNT_WIDTH-1:0] branch_cnt,
    output logic [CNT_WIDTH-1:0] mispred_cnt
);

    localparam int IDX_BITS = $clog2(BTB_DEPTH);
    localparam int TAG_W    = PC_WIDTH - IDX_BITS - 2;
    localparam logic [PC_WIDTH-1:0]  PC_STEP = {{(PC_WIDTH-3){1'b0}}, 3'b100};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic                 PRED_ON = (PREDICT_EN != 0);

    npc_op_e             op_s;
    btb_entry_t          if_entry_s, ex_entry_s, wr_entry_s;
    logic [TAG_W-1:0]    if_tag_s, ex_tag_s;
    logic [PC_WIDTH-1:0] if_target_s, ex_rd_target_s, wr_target_s;
    logic                if_hit_s, ex_hit_s, actual_taken_s, pred_taken_s, mispredict_s, wr_en_s;

    btb_array #(
        .PC_WIDTH (PC_WIDTH),
        .BTB_DEPTH(BTB_DEPTH)
    ) u_btb (
        .clk      (clk),
        .rst      (rst),
        .if_idx   (if_pc[IDX_BITS+1:2]),
        .if_entry (if_entry_s),
        .if_tag   (if_tag_s),
        .if_target(if_target_s),
        .ex_idx   (ex_pc[IDX_BITS+1:2]),
        .ex_entry (ex_entry_s),
        .ex_tag   (ex_tag_s),
        .ex_target(ex_rd_target_s),
        .wr_en    (wr_en_s),
        .wr_idx   (ex_pc[IDX_BITS+1:2]),
        .wr_entry (wr_entry_s),
        .wr_tag   (ex_pc[PC_WIDTH-1:IDX_BITS+2]),
        .wr_target(wr_target_s)
    );

    assign op_s     = npc_op_e'(ex_npc_op);
    assign if_hit_s = if_entry_s.valid && (if_tag_s == if_pc[PC_WIDTH-1:IDX_BITS+2]);
    assign ex_hit_s = ex_entry_s.valid && (ex_tag_s == ex_pc[PC_WIDTH-1:IDX_BITS+2]);

    assign if_pred_taken  = PRED_ON & if_hit_s & if_entry_s.ctr[1];
    assign if_pred_target = if_target_s;

    // Without prediction the carried-down guess is ignored, so every taken transfer mispredicts.
    assign actual_taken_s = (op_s == NPC_JAL) || (op_s == NPC_JALR) ||
                            ((op_s == NPC_BR) && ex_branch && alu_branch);
    assign pred_taken_s   = PRED_ON & ex_pred_taken;
    assign mispredict_s   = ex_valid && ((actual_taken_s != pred_taken_s) ||
                            (actual_taken_s && (ex_pred_target != ex_target)));

    assign redirect    = mispredict_s;
    assign redirect_pc = actual_taken_s ? ex_target : (ex_pc + PC_STEP);

    // Training policy for the entry at ex_pc's index.
    always_comb begin
        wr_en_s     = 1'b0;
        wr_entry_s  = ex_entry_s;
        wr_target_s = ex_rd_target_s;
        if (PRED_ON && ex_valid) begin
            case (op_s)
                NPC_BR: begin
                    if (ex_hit_s) begin
                        wr_en_s        = 1'b1;
                        wr_entry_s.ctr = ctr_step(ex_entry_s.ctr, actual_taken_s);
                        if (actual_taken_s) begin
                            wr_target_s = ex_target;
                        end else begin
                            wr_target_s = ex_rd_target_s;
                        end
                    end else if (actual_taken_s) begin
                        wr_en_s     = 1'b1;
                        wr_entry_s  = '{valid: 1'b1, ctr: CTR_WT};
                        wr_target_s = ex_target;
                    end else begin
                        wr_en_s = 1'b0;
                    end
                end
                NPC_JAL, NPC_JALR: begin
                    wr_en_s     = 1'b1;
                    wr_entry_s  = '{valid: 1'b1, ctr: CTR_ST};
                    wr_target_s = ex_target;
                end
                NPC_SEQ: begin
                    // A sequential instruction hitting the table is an alias; drop the entry.
                    if (ex_hit_s) begin
                        wr_en_s          = 1'b1;
                        wr_entry_s.valid = 1'b0;
                    end else begin
                        wr_en_s = 1'b0;
                    end
                end
                default: begin
                    wr_en_s = 1'b0;
                end
            endcase
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else begin
            if (ex_valid && (op_s != NPC_SEQ) && (branch_cnt != '1)) begin
                branch_cnt <= branch_cnt + CNT_ONE;
            end
            if (mispredict_s && (mispred_cnt != '1)) begin
                mispred_cnt <= mispred_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Self-checking bench: directed predictor scenarios plus randomized traffic against an
// array-based reference model, with a predicting and a non-predicting instance side by side.
module tb_branch_resolve_ctrl;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc, ex_pc, ex_target, ex_pred_target;
    logic [1:0]  ex_npc_op;
    logic        ex_valid, ex_branch, alu_branch, ex_pred_taken;

    logic        pt1, pt0, rd1, rd0;
    logic [31:0] ptg1, ptg0, rpc1, rpc0, bc1, bc0, mc1, mc0;

    int n_vec = 0;
    int n_err = 0;

    bit          m_valid [DEPTH];
    logic [31:0] m_tag   [DEPTH];
    logic [31:0] m_tgt   [DEPTH];
    int          m_ctr   [DEPTH];
    logic [31:0] m_bc, m_mc, m_mc_np;

    always #5 clk = ~clk;

    branch_resolve_ctrl #(.PREDICT_EN(1)) u_dut (
        .clk(clk), .rst(rst), .if_pc(if_pc), .if_pred_taken(pt1), .if_pred_target(ptg1),
        .ex_valid(ex_valid), .ex_npc_op(ex_npc_op), .ex_branch(ex_branch), .alu_branch(alu_branch),
        .ex_pc(ex_pc), .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
        .ex_pred_target(ex_pred_target), .redirect(rd1), .redirect_pc(rpc1),
        .branch_cnt(bc1), .mispred_cnt(mc1)
    );

    branch_resolve_ctrl #(.PREDICT_EN(0)) u_dut_np (
        .clk(clk), .rst(rst), .if_pc(if_pc), .if_pred_taken(pt0), .if_pred_target(ptg0),
        .ex_valid(ex_valid), .ex_npc_op(ex_npc_op), .ex_branch(ex_branch), .alu_branch(alu_branch),
        .ex_pc(ex_pc), .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
        .ex_pred_target(ex_pred_target), .redirect(rd0), .redirect_pc(rpc0),
        .branch_cnt(bc0), .mispred_cnt(mc0)
    );

    function automatic int ix(input logic [31:0] pc);
        return int'((pc >> 2) % DEPTH);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_valid[ix(pc)] && (m_tag[ix(pc)] == (pc >> 8));
    endfunction

    function automatic bit m_pred(input logic [31:0] pc);
        return m_hit(pc) && (m_ctr[ix(pc)] >= 2);
    endfunction

    function automatic bit m_taken();
        return (ex_npc_op == 2'd1) || (ex_npc_op == 2'd3) ||
               ((ex_npc_op == 2'd2) && ex_branch && alu_branch);
    endfunction

    function automatic bit m_redir();
        return ex_valid && ((m_taken() != ex_pred_taken) ||
                            (m_taken() && (ex_pred_target != ex_target)));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = 1;
        end
        m_bc = 0; m_mc = 0; m_mc_np = 0;
    endtask

    task automatic alloc(input int i, input int c);
        m_valid[i] = 1'b1;
        m_tag[i]   = ex_pc >> 8;
        m_tgt[i]   = ex_target;
        m_ctr[i]   = c;
    endtask

    task automatic model_commit();
        int  i;
        bit  tk, hit;
        i   = ix(ex_pc);
        tk  = m_taken();
        hit = m_hit(ex_pc);
        if (ex_valid) begin
            if (ex_npc_op != 2'd0) m_bc++;
            if (m_redir()) m_mc++;
            if (tk) m_mc_np++;
            if (ex_npc_op == 2'd2) begin
                if (hit && tk) begin
                    m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                    m_tgt[i] = ex_target;
                end else if (hit) begin
                    m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
                end else if (tk) begin
                    alloc(i, 2);
                end
            end else if (ex_npc_op != 2'd0) begin
                alloc(i, 3);
            end else if (hit) begin
                m_valid[i] = 1'b0;
            end
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic br, input logic alu,
                         input logic [31:0] pc, input logic [31:0] tgt,
                         input logic ptk, input logic [31:0] ptgt);
        ex_valid = v; ex_npc_op = op; ex_branch = br; alu_branch = alu;
        ex_pc = pc; ex_target = tgt; ex_pred_taken = ptk; ex_pred_target = ptgt;
    endtask

    task automatic tick();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        if_pc = 32'h100;
        drive(1'b0, 2'd0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        model_reset();
        #12;
        n_vec++; if (pt1 !== 1'b0) begin n_err++; $display("FAIL reset_pred: got %b expected 0", pt1); end
        n_vec++; if (rd1 !== 1'b0) begin n_err++; $display("FAIL reset_redirect: got %b expected 0", rd1); end
        n_vec++; if (bc1 !== 32'd0 || mc1 !== 32'd0) begin
            n_err++; $display("FAIL reset_cnt: got %0d/%0d expected 0/0", bc1, mc1); end
        n_vec++; if (bc0 !== 32'd0 || mc0 !== 32'd0) begin
            n_err++; $display("FAIL reset_cnt_np: got %0d/%0d expected 0/0", bc0, mc0); end
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_branch_train();
        if_pc = 32'h100;
        drive(1'b1, 2'd2, 1'b1, 1'b1, 32'h100, 32'h80, 1'b0, 32'h0);
        @(negedge clk);
        n_vec++; if (pt1 !== 1'b0) begin n_err++; $display("FAIL cold_lookup: got %b expected 0", pt1); end
        n_vec++; if (rd1 !== 1'b1 || rpc1 !== 32'h80) begin
            n_err++; $display("FAIL first_taken: got %b/%h expected 1/00000080", rd1, rpc1); end
        n_vec++; if (rd0 !== 1'b1) begin n_err++; $display("FAIL first_taken_np: got %b expected 1", rd0); end
        tick();
        drive(1'b0, 2'd0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        n_vec++; if (pt1 !== 1'b1 || ptg1 !== 32'h80) begin
            n_err++; $display("FAIL trained_lookup: got %b/%h expected 1/00000080", pt1, ptg1); end
        n_vec++; if (pt0 !== 1'b0) begin n_err++; $display("FAIL np_pred: got %b expected 0", pt0); end
        tick();
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 2'd2, 1'b1, 1'b1, 32'h100, 32'h80, 1'b1, 32'h80);
            @(negedge clk);
            n_vec++; if (rd1 !== 1'b0) begin n_err++; $display("FAIL correct_pred %0d: got %b expected 0", k, rd1); end
            n_vec++; if (rd0 !== 1'b1) begin n_err++; $display("FAIL taken_np %0d: got %b expected 1", k, rd0); end
            tick();
        end
        drive(1'b1, 2'd2, 1'b1, 1'b0, 32'h100, 32'h80, 1'b1, 32'h80);
        @(negedge clk);
        n_vec++; if (rd1 !== 1'b1 || rpc1 !== 32'h104) begin
            n_err++; $display("FAIL not_taken: got %b/%h expected 1/00000104", rd1, rpc1); end
        n_vec++; if (rd0 !== 1'b0) begin n_err++; $display("FAIL not_taken_np: got %b expected 0", rd0); end
        tick();
        drive(1'b0, 2'd0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        n_vec++; if (pt1 !== 1'b1) begin n_err++; $display("FAIL still_taken: got %b expected 1", pt1); end
        n_vec++; if (bc1 !== 32'd4 || mc1 !== 32'd2 || mc0 !== 32'd3) begin
            n_err++; $display("FAIL train_cnt: got %0d/%0d/%0d expected 4/2/3", bc1, mc1, mc0); end
        tick();
    endtask

    task automatic test_jalr_alias();
        drive(1'b1, 2'd3, 1'b0, 1'b0, 32'h200, 32'h340, 1'b1, 32'h300);
        @(negedge clk);
        n_vec++; if (rd1 !== 1'b1 || rpc1 !== 32'h340) begin
            n_err++; $display("FAIL jalr_target: got %b/%h expected 1/00000340", rd1, rpc1); end
        tick();
        drive(1'b0, 2'd0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        if_pc = 32'h200;
        #1;
        n_vec++; if (pt1 !== 1'b1 || ptg1 !== 32'h340) begin
            n_err++; $display("FAIL jalr_entry: got %b/%h expected 1/00000340", pt1, ptg1); end
        if_pc = 32'h100;
        #1;
        n_vec++; if (pt1 !== 1'b0) begin n_err++; $display("FAIL alias_miss: got %b expected 0", pt1); end
        tick();
        if_pc = 32'h200;
        drive(1'b1, 2'd0, 1'b0, 1'b0, 32'h200, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        n_vec++; if (rd1 !== 1'b0 || rpc1 !== 32'h204) begin
            n_err++; $display("FAIL seq_alias: got %b/%h expected 0/00000204", rd1, rpc1); end
        tick();
        drive(1'b0, 2'd0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        #1;
        n_vec++; if (pt1 !== 1'b0) begin n_err++; $display("FAIL invalidated: got %b expected 0", pt1); end
        tick();
    endtask

    task automatic test_bubble();
        drive(1'b0, 2'd1, 1'b0, 1'b0, 32'h300, 32'h400, 1'b0, 32'h0);
        @(negedge clk);
        n_vec++; if (rd1 !== 1'b0 || rd0 !== 1'b0) begin
            n_err++; $display("FAIL bubble_redirect: got %b/%b expected 0/0", rd1, rd0); end
        tick();
        n_vec++; if (bc1 !== m_bc || mc1 !== m_mc || mc0 !== m_mc_np) begin
            n_err++; $display("FAIL bubble_cnt: got %0d/%0d/%0d expected %0d/%0d/%0d",
                              bc1, mc1, mc0, m_bc, m_mc, m_mc_np); end
        if_pc = 32'h300;
        #1;
        n_vec++; if (pt1 !== 1'b0) begin n_err++; $display("FAIL bubble_no_write: got %b expected 0", pt1); end
    endtask

    task automatic test_random();
        logic [31:0] pcs [6];
        logic [31:0] tgs [4];
        logic [31:0] p;
        logic [1:0]  op;
        pcs = '{32'h100, 32'h104, 32'h200, 32'h300, 32'h1100, 32'h40};
        tgs = '{32'h80, 32'h340, 32'h500, 32'h104};
        for (int n = 0; n < 400; n++) begin
            p  = pcs[$urandom_range(5)];
            op = 2'($urandom_range(3));
            if ($urandom_range(1) == 0 && m_pred(p)) begin
                drive($urandom_range(7) != 0, op, op == 2'd2 || $urandom_range(3) == 0,
                      1'($urandom_range(1)), p, tgs[$urandom_range(3)], 1'b1, m_tgt[ix(p)]);
            end else begin
                drive($urandom_range(7) != 0, op, op == 2'd2 || $urandom_range(3) == 0,
                      1'($urandom_range(1)), p, tgs[$urandom_range(3)],
                      1'($urandom_range(1)), tgs[$urandom_range(3)]);
            end
            if_pc = pcs[$urandom_range(5)];
            @(negedge clk);
            n_vec++; if (pt1 !== m_pred(if_pc)) begin
                n_err++; $display("FAIL rnd_pred %0d: got %b expected %b", n, pt1, m_pred(if_pc)); end
            if (m_pred(if_pc)) begin
                n_vec++; if (ptg1 !== m_tgt[ix(if_pc)]) begin
                    n_err++; $display("FAIL rnd_pred_tgt %0d: got %h expected %h", n, ptg1, m_tgt[ix(if_pc)]); end
            end
            n_vec++; if (rd1 !== m_redir()) begin
                n_err++; $display("FAIL rnd_redirect %0d: got %b expected %b", n, rd1, m_redir()); end
            n_vec++; if (rd0 !== (ex_valid && m_taken()) || pt0 !== 1'b0) begin
                n_err++; $display("FAIL rnd_np %0d: got %b/%b expected %b/0", n, rd0, pt0, ex_valid && m_taken()); end
            n_vec++; if (rpc1 !== (m_taken() ? ex_target : ex_pc + 32'd4)) begin
                n_err++; $display("FAIL rnd_rpc %0d: got %h", n, rpc1); end
            tick();
            n_vec++; if (bc1 !== m_bc || mc1 !== m_mc || mc0 !== m_mc_np || bc0 !== m_bc) begin
                n_err++; $display("FAIL rnd_cnt %0d: got %0d/%0d/%0d expected %0d/%0d/%0d",
                                  n, bc1, mc1, mc0, m_bc, m_mc, m_mc_np); end
        end
    endtask

    task automatic test_reset_midrun();
        drive(1'b1, 2'd1, 1'b0, 1'b0, 32'h100, 32'h80, 1'b0, 32'h0);
        tick();
        drive(1'b0, 2'd0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        if_pc = 32'h100;
        @(negedge clk);
        n_vec++; if (pt1 !== 1'b1) begin n_err++; $display("FAIL pre_reset_pred: got %b expected 1", pt1); end
        #2 rst = 1'b1;
        #1;
        n_vec++; if (pt1 !== 1'b0) begin n_err++; $display("FAIL midrun_pred: got %b expected 0", pt1); end
        n_vec++; if (bc1 !== 32'd0 || mc1 !== 32'd0 || mc0 !== 32'd0) begin
            n_err++; $display("FAIL midrun_cnt: got %0d/%0d/%0d expected 0/0/0", bc1, mc1, mc0); end
        #1 rst = 1'b0;
        model_reset();
        tick();
        n_vec++; if (pt1 !== 1'b0 || bc1 !== 32'd0) begin
            n_err++; $display("FAIL post_reset: got %b/%0d expected 0/0", pt1, bc1); end
    endtask

    initial begin
        test_reset();
        test_branch_train();
        test_jalr_alias();
        test_bubble();
        test_random();
        test_reset_midrun();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
